// File: rtl/cr16_control_fsm_if.sv
// CR16 controller bus: stall control, fetch/memory handshakes and datapath control outputs.
// master = controller side, slave = memory/datapath side.
interface cr16_control_fsm_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  I_ENABLE;
  logic                  O_FETCH_REQ;
  logic                  I_FETCH_ACK;
  logic [ADDR_WIDTH-1:0] O_PC;
  logic [15:0]           I_INSTR;
  logic                  O_MEM_REQ;
  logic                  O_MEM_WE;
  logic                  I_MEM_ACK;
  logic [15:0]           I_MEM_RDATA;
  logic [15:0]           O_REG_WRITE_ENABLE;
  logic [3:0]            O_REG_A_SELECT;
  logic [3:0]            O_REG_B_SELECT;
  logic [15:0]           O_IMMEDIATE;
  logic                  O_IMMEDIATE_SELECT;
  logic [3:0]            O_OPCODE;
  logic [15:0]           O_REGFILE_DATA;
  logic                  O_REGFILE_DATA_SELECT;
  logic                  O_HALTED;

  modport master (
    input  I_ENABLE, I_FETCH_ACK, I_INSTR, I_MEM_ACK, I_MEM_RDATA,
    output O_FETCH_REQ, O_PC, O_MEM_REQ, O_MEM_WE, O_REG_WRITE_ENABLE,
           O_REG_A_SELECT, O_REG_B_SELECT, O_IMMEDIATE, O_IMMEDIATE_SELECT,
           O_OPCODE, O_REGFILE_DATA, O_REGFILE_DATA_SELECT, O_HALTED
  );

  modport slave (
    output I_ENABLE, I_FETCH_ACK, I_INSTR, I_MEM_ACK, I_MEM_RDATA,
    input  O_FETCH_REQ, O_PC, O_MEM_REQ, O_MEM_WE, O_REG_WRITE_ENABLE,
           O_REG_A_SELECT, O_REG_B_SELECT, O_IMMEDIATE, O_IMMEDIATE_SELECT,
           O_OPCODE, O_REGFILE_DATA, O_REGFILE_DATA_SELECT, O_HALTED
  );
endinterface

// File: rtl/cr16_control_fsm.sv
// CR16 instruction sequencer: fetch -> decode -> exec (-> mem), driving all datapath controls.
// Owns the PC; LOAD/STOR run over the data memory handshake.
module cr16_control_fsm #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic                I_CLK,
  input logic                I_NRESET,
  cr16_control_fsm_if.master bus
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_e;
  typedef enum logic [2:0] {K_NOP, K_WRITE, K_LOAD, K_STOR, K_HALT} kind_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_ADDU, OP_ADDC, OP_ADDCU, OP_SUB, OP_MUL, OP_AND,
    OP_OR, OP_XOR, OP_NOT, OP_LSH, OP_RSH, OP_ALSH, OP_ARSH
  } alu_op_e;

  state_e                state_q, state_d;
  kind_e                 kind_q, kind_d;
  logic [3:0]            rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  fetch_req_q, fetch_req_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            a_sel_q, a_sel_d, b_sel_q, b_sel_d, opcode_q, opcode_d;
  logic [15:0]           imm_q, imm_d, rf_data_q, rf_data_d, wr_en_q, wr_en_d;
  logic                  imm_sel_q, imm_sel_d, rf_data_sel_q, rf_data_sel_d;
  logic                  halted_q, halted_d;

  kind_e       dec_kind;
  logic [3:0]  dec_a, dec_b, dec_opc;
  logic [15:0] dec_imm, dec_rf_data;
  logic        dec_imm_sel, dec_rf_sel;
  logic        clear_dec;
  logic        load_ack;

  // Decode straight off the fetch bus so the controls are registered by the first DECODE cycle.
  always_comb begin
    dec_kind    = K_NOP;
    dec_a       = '0;
    dec_b       = '0;
    dec_opc     = OP_ADD;
    dec_imm     = '0;
    dec_imm_sel = 1'b0;
    dec_rf_data = '0;
    dec_rf_sel  = 1'b0;
    case (bus.I_INSTR[15:12])
      4'h0: begin
        if (bus.I_INSTR[7:4] == 4'hE) begin
          dec_kind = K_WRITE;
          dec_a    = bus.I_INSTR[3:0];
          dec_b    = bus.I_INSTR[3:0];
          dec_opc  = OP_OR;
        end else if (bus.I_INSTR[7:4] != 4'hF) begin
          dec_kind = K_WRITE;
          dec_a    = bus.I_INSTR[11:8];
          dec_b    = bus.I_INSTR[3:0];
          dec_opc  = bus.I_INSTR[7:4];
        end
      end
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7: begin
        dec_kind    = K_WRITE;
        dec_a       = bus.I_INSTR[11:8];
        dec_imm_sel = 1'b1;
        dec_imm     = {8'h00, bus.I_INSTR[7:0]};
        case (bus.I_INSTR[15:12])
          4'h1:    dec_opc = OP_ADD;
          4'h2:    dec_opc = OP_SUB;
          4'h3:    dec_opc = OP_AND;
          4'h4:    dec_opc = OP_OR;
          4'h5:    dec_opc = OP_XOR;
          default: dec_opc = OP_LSH;
        endcase
        if (bus.I_INSTR[15:12] == 4'h1 || bus.I_INSTR[15:12] == 4'h2) begin
          dec_imm = {{8{bus.I_INSTR[7]}}, bus.I_INSTR[7:0]};
        end
      end
      4'h6: begin
        dec_kind    = K_WRITE;
        dec_rf_data = {8'h00, bus.I_INSTR[7:0]};
        dec_rf_sel  = 1'b1;
      end
      4'h8: begin
        dec_kind   = K_LOAD;
        dec_b      = bus.I_INSTR[3:0];
        dec_rf_sel = 1'b1;
      end
      4'h9: begin
        dec_kind = K_STOR;
        dec_a    = bus.I_INSTR[11:8];
        dec_b    = bus.I_INSTR[3:0];
      end
      4'hF:    dec_kind = K_HALT;
      default: dec_kind = K_NOP;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    rd_d          = rd_q;
    pc_d          = pc_q;
    fetch_req_d   = fetch_req_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    a_sel_d       = a_sel_q;
    b_sel_d       = b_sel_q;
    opcode_d      = opcode_q;
    imm_d         = imm_q;
    imm_sel_d     = imm_sel_q;
    rf_data_d     = rf_data_q;
    rf_data_sel_d = rf_data_sel_q;
    wr_en_d       = wr_en_q;
    halted_d      = halted_q;
    clear_dec     = 1'b0;
    if (bus.I_ENABLE) begin
      case (state_q)
        S_FETCH: begin
          if (!fetch_req_q) begin
            fetch_req_d = 1'b1;
          end else if (bus.I_FETCH_ACK) begin
            fetch_req_d   = 1'b0;
            state_d       = S_DECODE;
            kind_d        = dec_kind;
            rd_d          = bus.I_INSTR[11:8];
            a_sel_d       = dec_a;
            b_sel_d       = dec_b;
            opcode_d      = dec_opc;
            imm_d         = dec_imm;
            imm_sel_d     = dec_imm_sel;
            rf_data_d     = dec_rf_data;
            rf_data_sel_d = dec_rf_sel;
          end
        end
        S_DECODE: begin
          state_d = S_EXEC;
          wr_en_d = (kind_q == K_WRITE) ? (16'd1 << rd_q) : '0;
        end
        S_EXEC: begin
          wr_en_d = '0;
          case (kind_q)
            K_LOAD, K_STOR: begin
              state_d   = S_MEM;
              mem_req_d = 1'b1;
              mem_we_d  = (kind_q == K_STOR);
            end
            K_HALT: begin
              state_d   = S_HALT;
              halted_d  = 1'b1;
              clear_dec = 1'b1;
            end
            default: begin
              state_d     = S_FETCH;
              fetch_req_d = 1'b1;
              pc_d        = pc_q + ADDR_WIDTH'(1);
              clear_dec   = 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (mem_req_q && bus.I_MEM_ACK) begin
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            state_d     = S_FETCH;
            fetch_req_d = 1'b1;
            pc_d        = pc_q + ADDR_WIDTH'(1);
            clear_dec   = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (clear_dec) begin
      a_sel_d       = '0;
      b_sel_d       = '0;
      opcode_d      = '0;
      imm_d         = '0;
      imm_sel_d     = 1'b0;
      rf_data_d     = '0;
      rf_data_sel_d = 1'b0;
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q       <= S_FETCH;
      kind_q        <= K_NOP;
      rd_q          <= '0;
      pc_q          <= RESET_PC;
      fetch_req_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      a_sel_q       <= '0;
      b_sel_q       <= '0;
      opcode_q      <= '0;
      imm_q         <= '0;
      imm_sel_q     <= 1'b0;
      rf_data_q     <= '0;
      rf_data_sel_q <= 1'b0;
      wr_en_q       <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      rd_q          <= rd_d;
      pc_q          <= pc_d;
      fetch_req_q   <= fetch_req_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      a_sel_q       <= a_sel_d;
      b_sel_q       <= b_sel_d;
      opcode_q      <= opcode_d;
      imm_q         <= imm_d;
      imm_sel_q     <= imm_sel_d;
      rf_data_q     <= rf_data_d;
      rf_data_sel_q <= rf_data_sel_d;
      wr_en_q       <= wr_en_d;
      halted_q      <= halted_d;
    end
  end

  // Load write-back lands in the ack cycle itself, so the strobe and data bypass the registers.
  assign load_ack = (state_q == S_MEM) && (kind_q == K_LOAD) && mem_req_q && bus.I_MEM_ACK;

  assign bus.O_REG_WRITE_ENABLE    = bus.I_ENABLE ? (wr_en_q | (load_ack ? (16'd1 << rd_q) : 16'd0)) : '0;
  assign bus.O_REGFILE_DATA        = (state_q == S_MEM && kind_q == K_LOAD) ? bus.I_MEM_RDATA : rf_data_q;
  assign bus.O_REGFILE_DATA_SELECT = rf_data_sel_q;
  assign bus.O_FETCH_REQ           = fetch_req_q;
  assign bus.O_PC                  = pc_q;
  assign bus.O_MEM_REQ             = mem_req_q;
  assign bus.O_MEM_WE              = mem_we_q;
  assign bus.O_REG_A_SELECT        = a_sel_q;
  assign bus.O_REG_B_SELECT        = b_sel_q;
  assign bus.O_IMMEDIATE           = imm_q;
  assign bus.O_IMMEDIATE_SELECT    = imm_sel_q;
  assign bus.O_OPCODE              = opcode_q;
  assign bus.O_HALTED              = halted_q;
endmodule
